ps2_host_tx: RTL
================

Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It is the opposite direction of the keyboard receiver and sends command bytes to the keyboard, for example 0xED set-LEDs, 0xFF reset and 0xF4 enable.
- Drives the shared open-drain PS2_CLK/PS2_DATA lines through low-only output enables.
- Runs the inhibit, request-to-send, bit-shift and acknowledge sequence.
- Raises tx_busy so the receiver ignores its own frames during transmission.
- Sits beside the keyboard receiver in the clk domain, 100 MHz.

Parameters:
CLK_HZ, 100000000, clk frequency in Hz
INHIBIT_US, 100, minimum time the clock line is held low before request-to-send
TIMEOUT_US, 15000, watchdog reloaded at request-to-send and at every device falling edge
MAX_RETRY, 2, retries after NACK/timeout (used only with PS2_TX_RETRY_EN)

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
tx_data  in  8  command byte
tx_valid  in  1  request; byte accepted when tx_valid && tx_ready
tx_ready  out  1  high only in IDLE
tx_busy  out  1  high in every state except IDLE; gates the receiver
tx_done  out  1  one-cycle pulse: device acknowledged
tx_err  out  1  one-cycle pulse: NACK or timeout (after retries are exhausted)
ps2_clk_i  in  1  raw PS2_CLK line, asynchronous
ps2_data_i  in  1  raw PS2_DATA line, asynchronous
ps2_clk_oe  out  1  1 = pull PS2_CLK low, 0 = release
ps2_data_oe  out  1  1 = pull PS2_DATA low, 0 = release

Behaviour:
- Reset: rstn is asynchronous, active-low; clock is clk. While reset is asserted:
  - tx_ready=1, tx_busy=0, tx_done=0, tx_err=0.
  - ps2_clk_oe=0, ps2_data_oe=0.
  - FSM in IDLE; shift register, bit count and timers cleared.
  - Reset mid-frame releases both lines immediately, in the same cycle and without waiting for a clock edge.
- Input sync:
  - ps2_clk_i and ps2_data_i each pass through 2 flops.
  - fall = sync_clk_d & ~sync_clk; detection latency is 3 clk.
- Acceptance: on tx_valid && tx_ready, latch {odd parity = ~^tx_data, tx_data}. tx_valid while busy is ignored, with no queueing.
- FSM:
  - IDLE: oe=00. On accept, go to INHIBIT.
  - INHIBIT: ps2_clk_oe=1 for exactly CLK_HZ/1e6*INHIBIT_US cycles (10000 at default).
    - In the last INHIBIT cycle, set ps2_data_oe=1 (start bit 0).
    - Then go to RTS.
  - RTS: ps2_clk_oe=0, ps2_data_oe=1. Load the watchdog; wait for fall.
  - SHIFT: on each fall, drive the next bit and increment bit_cnt (4 bits, 0..10). ps2_data_oe = ~bit, so a 1 releases the line.
    - fall 1-8: d0..d7, LSB first.
    - fall 9: parity.
    - fall 10: release data (stop bit); go to ACK.
  - ACK: on fall 11, sample sync_data.
    - 0 → WAIT_IDLE.
    - 1 → NACK.
  - WAIT_IDLE: wait until sync_clk=1 && sync_data=1, then pulse tx_done for 1 cycle and go to IDLE.
- Watchdog:
  - Counter width = clog2(CLK_HZ/1e6*TIMEOUT_US + 1).
  - Reloaded on entry to RTS and on every fall; counts down in RTS, SHIFT, ACK and WAIT_IDLE.
  - At 0: release both lines, abort the frame and treat it as a NACK.
- NACK/timeout: without the retry feature, pulse tx_err for 1 cycle and go to IDLE.
- Falls seen in IDLE or INHIBIT are ignored; the device-to-host receiver handles them.
- tx_done and tx_err never assert in the same cycle.

Optional Feature:
PS2_TX_RETRY_EN
- Defined:
  - On NACK or timeout, if retry_cnt < MAX_RETRY, increment retry_cnt and re-enter INHIBIT with the latched byte.
  - tx_err pulses only when a failure occurs with retry_cnt == MAX_RETRY.
  - retry_cnt clears on accept.
- Undefined: no retry logic and no retry_cnt register; the first failure pulses tx_err.

Decomposition:
- Shared package ps2_pkg:
  - FSM state encoding: IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE.
  - PS/2 command constants: CMD_SET_LED=8'hED, CMD_RESET=8'hFF, CMD_ENABLE=8'hF4, RSP_ACK=8'hFA.
  - FRAME_BITS=11.
- One natural sub-module: ps2_line_sync (2-flop sync + falling-edge detect). It can also be reused by the receiver.

Test Plan:
- Send tx_data=0xED with a device model clocking at 12.5 kHz.
  - Required: clk held low for 10000 cycles.
  - Line samples at rising edges 1..10 are 1,0,1,1,0,1,1,1, parity=1, stop=1.
  - Model ACK gives tx_done after bus idle; tx_err=0.
- Send 0x01 → parity bit 0 sampled. Send 0x00 → parity 1.
- Device never clocks after RTS → tx_err pulses after 1,500,000 cycles.
  - Both oe=0 from then on; tx_ready=1 the next cycle.
- Model drives data high at the 11th fall (NACK):
  - Without the macro: tx_err pulse.
  - With PS2_TX_RETRY_EN: 3 INHIBIT phases, then tx_err.
  - With the macro and ACK on the 2nd attempt: tx_done and no tx_err.
- Assert rstn low mid-SHIFT (after fall 4) → ps2_clk_oe=ps2_data_oe=0 combinationally with reset. After release: tx_ready=1, tx_busy=0.
- Pulse tx_valid with 0x55 while busy sending 0xF4 → only 0xF4 is transmitted; exactly one tx_done.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter FSM states,
// keyboard command bytes and frame geometry.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SHIFT,
    ACK,
    WAIT_IDLE
  } ps2_tx_state_e;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] RSP_ACK     = 8'hFA;

  localparam int FRAME_BITS = 11;

  function automatic logic odd_par(
    input logic [7:0] d
  );
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronisers for PS2_CLK/PS2_DATA plus falling-edge strobe.
// Ports: clk, rstn, ps2_clk_i, ps2_data_i -> sync_clk, sync_data, fall.
module ps2_line_sync (
  input  logic clk,
  input  logic rstn,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic sync_clk,
  output logic sync_data,
  output logic fall
);

  logic clk_m;
  logic data_m;
  logic sync_clk_d;

  // Lines idle high, so reset to 1 to avoid a false fall.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clk_m      <= 1'b1;
      sync_clk   <= 1'b1;
      sync_clk_d <= 1'b1;
      data_m     <= 1'b1;
      sync_data  <= 1'b1;
    end else begin
      clk_m      <= ps2_clk_i;
      sync_clk   <= clk_m;
      sync_clk_d <= sync_clk;
      data_m     <= ps2_data_i;
      sync_data  <= data_m;
    end
  end

  assign fall = sync_clk_d & ~sync_clk;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, RTS, shift, ack).
// Ports: tx_data/tx_valid/tx_ready in, tx_busy/tx_done/tx_err status,
// ps2_clk_i/ps2_data_i raw lines, ps2_clk_oe/ps2_data_oe pull-low enables.
// Optional: define PS2_TX_RETRY_EN to retry up to MAX_RETRY times.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 100000000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_US = 15000,
  parameter int MAX_RETRY  = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int CYC_US  = CLK_HZ / 1000000;
  localparam int INH_CYC = CYC_US * INHIBIT_US;
  localparam int TO_CYC  = CYC_US * TIMEOUT_US;
  localparam int INH_W   = $clog2(INH_CYC + 1);
  localparam int WD_W    = $clog2(TO_CYC + 1);

  ps2_tx_state_e state_q, state_d;

  logic             sync_clk;
  logic             sync_data;
  logic             fall;
  logic [INH_W-1:0] inh_q;
  logic [WD_W-1:0]  wd_q;
  logic [9:0]       sh_q;
  logic [3:0]       cnt_q;
  logic             bit_q;
  logic [8:0]       frame_src;
  logic             ld_inh;
  logic             ld_wd;
  logic             shift;
  logic             fail;
  logic             wd_run;
  logic             wd_zero;

  ps2_line_sync u_sync (
    .clk        (clk),
    .rstn       (rstn),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .sync_clk   (sync_clk),
    .sync_data  (sync_data),
    .fall       (fall)
  );

`ifdef PS2_TX_RETRY_EN
  localparam int RW = $clog2(MAX_RETRY + 2);

  logic [RW-1:0] retry_q;
  logic [8:0]    frame_q;
  logic          retry;
  logic          accept;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      retry_q <= '0;
      frame_q <= '0;
    end else if (accept) begin
      retry_q <= '0;
      frame_q <= {odd_par(tx_data), tx_data};
    end else if (retry) begin
      retry_q <= retry_q + 1'b1;
    end
  end

  assign frame_src = accept ? {odd_par(tx_data), tx_data}
                            : frame_q;
`else
  assign frame_src = {odd_par(tx_data), tx_data};
`endif

  assign wd_zero = (wd_q == '0);
  assign wd_run  = (state_q == RTS) || (state_q == SHIFT) ||
                   (state_q == ACK) || (state_q == WAIT_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    ld_inh      = 1'b0;
    ld_wd       = 1'b0;
    shift       = 1'b0;
    fail        = 1'b0;
    tx_done     = 1'b0;
    tx_err      = 1'b0;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry       = 1'b0;
    accept      = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (tx_valid) begin
`ifdef PS2_TX_RETRY_EN
          accept  = 1'b1;
`endif
          ld_inh  = 1'b1;
          state_d = INHIBIT;
        end
      end
      INHIBIT: begin
        ps2_clk_oe = 1'b1;
        // Start bit goes low while the clock is still held.
        if (inh_q == '0) begin
          ps2_data_oe = 1'b1;
          ld_wd       = 1'b1;
          state_d     = RTS;
        end
      end
      RTS: begin
        ps2_data_oe = 1'b1;
        if (wd_zero) begin
          fail = 1'b1;
        end else if (fall) begin
          shift   = 1'b1;
          ld_wd   = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        ps2_data_oe = ~bit_q;
        if (wd_zero) begin
          fail = 1'b1;
        end else if (fall) begin
          shift = 1'b1;
          ld_wd = 1'b1;
          if (cnt_q == 4'(FRAME_BITS - 2))
            state_d = ACK;
        end
      end
      ACK: begin
        if (wd_zero) begin
          fail = 1'b1;
        end else if (fall) begin
          ld_wd = 1'b1;
          if (sync_data) fail = 1'b1;
          else           state_d = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (wd_zero) begin
          fail = 1'b1;
        end else if (sync_clk && sync_data) begin
          tx_done = 1'b1;
          state_d = IDLE;
        end else if (fall) begin
          ld_wd = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Failure releases both lines in the same cycle.
    if (fail) begin
      ps2_clk_oe  = 1'b0;
      ps2_data_oe = 1'b0;
      ld_wd       = 1'b0;
      shift       = 1'b0;
`ifdef PS2_TX_RETRY_EN
      if (retry_q < RW'(MAX_RETRY)) begin
        retry   = 1'b1;
        ld_inh  = 1'b1;
        state_d = INHIBIT;
      end else begin
        tx_err  = 1'b1;
        state_d = IDLE;
      end
`else
      tx_err  = 1'b1;
      state_d = IDLE;
`endif
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inh_q <= '0;
      wd_q  <= '0;
      sh_q  <= '0;
      cnt_q <= '0;
      bit_q <= 1'b1;
    end else begin
      if (ld_inh) begin
        inh_q <= INH_W'(INH_CYC - 1);
        sh_q  <= {1'b1, frame_src};
        cnt_q <= '0;
        bit_q <= 1'b1;
      end else if (state_q == INHIBIT) begin
        inh_q <= inh_q - 1'b1;
      end
      if (ld_wd)
        wd_q <= WD_W'(TO_CYC);
      else if (wd_run && !wd_zero)
        wd_q <= wd_q - 1'b1;
      // Shifting in 1s leaves the stop bit (release) last.
      if (shift) begin
        bit_q <= sh_q[0];
        sh_q  <= {1'b1, sh_q[9:1]};
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign tx_ready = (state_q == IDLE);
  assign tx_busy  = ~tx_ready;

endmodule
